// File: rtl/word_cfg_pkg.sv
// Shared definitions for the word configuration loader: field indices,
// FSM state encoding and the field-walk helper functions.
package word_cfg_pkg;

    localparam int NUM_FIELDS = 4;

    localparam logic [1:0] FLD_X  = 2'd0;
    localparam logic [1:0] FLD_Y  = 2'd1;
    localparam logic [1:0] FLD_AB = 2'd2;
    localparam logic [1:0] FLD_CX = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result of one step through the field mask: the next field to write
    // and whether the walk wrapped back to the lowest field (next block).
    typedef struct packed {
        logic       wrap;
        logic [1:0] fld;
    } fld_step_t;

    // Lowest set bit of the mask; x when the mask is empty (never used then).
    function automatic logic [1:0] first_field(input logic [NUM_FIELDS-1:0] mask);
        logic [1:0] r;
        logic       found;
        r     = FLD_X;
        found = 1'b0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (!found && mask[i]) begin
                r     = 2'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Lowest set mask bit strictly above cur; wraps to the lowest set bit.
    function automatic fld_step_t next_field(input logic [NUM_FIELDS-1:0] mask,
                                             input logic [1:0]            cur);
        fld_step_t r;
        logic      found;
        r.fld  = first_field(mask);
        r.wrap = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (!found && (i > int'(cur)) && mask[i]) begin
                r.fld  = 2'(i);
                r.wrap = 1'b0;
                found  = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/word_cfg_loader.sv
// Byte-stream configuration sequencer for one word of logic blocks.
// Bytes are written block-major, fields ascending within a block, with
// masked-off fields skipped. Every output except in_ready is registered.
module word_cfg_loader
    import word_cfg_pkg::*;
#(
    parameter int NUM_BLOCKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] field_mask,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] cfg_in,
    output logic [2:0] cfg_addr,
    output logic       set_x,
    output logic       set_y,
    output logic       set_ab,
    output logic       set_cx,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] LAST_BLK = 3'(NUM_BLOCKS - 1);

    state_t     state_q, state_d;
    logic [3:0] mask_q, mask_d;
    logic [2:0] blk_q, blk_d;
    logic [1:0] fld_q, fld_d;
    logic [7:0] cfg_in_q, cfg_in_d;
    logic [2:0] cfg_addr_q, cfg_addr_d;
    logic [3:0] strb_q, strb_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       xfer;
    logic       last_xfer;
    logic       start_ok;
    fld_step_t  step;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort has priority over start and over a transfer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = (field_mask == 4'd0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_xfer) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output/datapath logic: handshake decode and next values of the registered outputs.
    always_comb begin
        in_ready  = (state_q == LOAD) && !abort;
        xfer      = in_ready && in_valid;
        start_ok  = (state_q == IDLE) && start && !abort;
        step      = next_field(mask_q, fld_q);
        last_xfer = xfer && step.wrap && (blk_q == LAST_BLK);

        mask_d     = mask_q;
        blk_d      = blk_q;
        fld_d      = fld_q;
        cfg_in_d   = cfg_in_q;
        cfg_addr_d = cfg_addr_q;
        strb_d     = 4'd0;

        if (start_ok) begin
            mask_d = field_mask;
            blk_d  = 3'd0;
            fld_d  = first_field(field_mask);
        end

        if (xfer) begin
            cfg_in_d   = in_data;
            cfg_addr_d = blk_q;
            strb_d     = 4'b0001 << fld_q;
            fld_d      = step.fld;
            if (step.wrap) begin
                blk_d = blk_q + 3'd1;
            end
        end

        busy_d = (state_d == LOAD);
        done_d = (state_d == DONE);
    end

    // Walk position, latched mask and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= 4'd0;
            blk_q      <= 3'd0;
            fld_q      <= 2'd0;
            cfg_in_q   <= 8'd0;
            cfg_addr_q <= 3'd0;
            strb_q     <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            blk_q      <= blk_d;
            fld_q      <= fld_d;
            cfg_in_q   <= cfg_in_d;
            cfg_addr_q <= cfg_addr_d;
            strb_q     <= strb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cfg_in   = cfg_in_q;
    assign cfg_addr = cfg_addr_q;
    assign set_x    = strb_q[FLD_X];
    assign set_y    = strb_q[FLD_Y];
    assign set_ab   = strb_q[FLD_AB];
    assign set_cx   = strb_q[FLD_CX];
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_word_cfg_loader.sv
// Scoreboard bench for word_cfg_loader: expected strobes are generated from
// the mask and byte stream when a load is launched and matched as they appear.
module tb_word_cfg_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] field_mask;
    logic       abort;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] cfg_in;
    logic [2:0] cfg_addr;
    logic       set_x, set_y, set_ab, set_cx;
    logic       busy;
    logic       done;

    word_cfg_loader #(.NUM_BLOCKS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .field_mask (field_mask),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cfg_in     (cfg_in),
        .cfg_addr   (cfg_addr),
        .set_x      (set_x),
        .set_y      (set_y),
        .set_ab     (set_ab),
        .set_cx     (set_cx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] strb;
        logic [2:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int strobe_cnt;
    int done_cnt;
    int first_strobe_cyc;
    int last_strobe_cyc;
    int done_cyc;
    bit ready_seen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: match every strobe against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [3:0] s;
            exp_t       e;
            s = {set_cx, set_ab, set_y, set_x};
            if (in_ready) ready_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (s != 4'd0) begin
                if (strobe_cnt == 0) first_strobe_cyc = cyc;
                last_strobe_cyc = cyc;
                strobe_cnt++;
                if (sb_q.size() == 0) begin
                    check_val("unexpected_strobe", {24'd0, cfg_in}, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check_val("strobe", {28'd0, s}, {28'd0, e.strb});
                    check_val("addr", {29'd0, cfg_addr}, {29'd0, e.addr});
                    check_val("data", {24'd0, cfg_in}, {24'd0, e.data});
                end
            end
        end
    end

    task automatic clear_stats();
        strobe_cnt       = 0;
        done_cnt         = 0;
        first_strobe_cyc = -1;
        last_strobe_cyc  = -1;
        done_cyc         = -1;
        ready_seen       = 1'b0;
    endtask

    // Reference order: block-major, fields ascending, masked fields skipped.
    task automatic push_expected(input logic [3:0] mask, input logic [7:0] base, input int count);
        int k;
        exp_t e;
        k = 0;
        for (int b = 0; b < 8; b++) begin
            for (int f = 0; f < 4; f++) begin
                if (mask[f] && k < count) begin
                    e.strb = 4'b0001 << f;
                    e.addr = 3'(b);
                    e.data = base + 8'(k);
                    sb_q.push_back(e);
                    k++;
                end
            end
        end
    endtask

    task automatic do_start(input logic [3:0] mask);
        start      = 1'b1;
        field_mask = mask;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("busy_after_start", {31'd0, busy}, {31'd0, (mask != 4'd0)});
        check_val("done_after_start", {31'd0, done}, {31'd0, (mask == 4'd0)});
    endtask

    task automatic send_stream(input logic [7:0] base, input int n, input bit throttle,
                               input int start_at);
        int k;
        int iter;
        k    = 0;
        iter = 0;
        while (k < n && iter < 2000) begin
            start    = (iter == start_at);
            if (iter == start_at) field_mask = 4'h3;
            in_data  = base + 8'(k);
            in_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
            iter++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (k < n) check_val("stream_timeout", k, n);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_strobes"}, {28'd0, set_cx, set_ab, set_y, set_x}, 32'd0);
        check_val({tag, "_cfg_in"}, {24'd0, cfg_in}, 32'd0);
        check_val({tag, "_cfg_addr"}, {29'd0, cfg_addr}, 32'd0);
        check_val({tag, "_ctrl"}, {29'd0, in_ready, busy, done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        field_mask = 4'd0;
        abort      = 1'b0;
        in_data    = 8'd0;
        in_valid   = 1'b0;
        clear_stats();
        idle_cycles(2);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        // Full load, in_valid held high.
        clear_stats();
        push_expected(4'hF, 8'h00, 32);
        do_start(4'hF);
        check_val("ready_after_start", {31'd0, in_ready}, 32'd1);
        send_stream(8'h00, 32, 1'b0, -1);
        idle_cycles(3);
        check_val("full_strobe_cnt", strobe_cnt, 32);
        check_val("full_back_to_back", last_strobe_cyc - first_strobe_cyc, 31);
        check_val("full_done_cnt", done_cnt, 1);
        check_val("full_done_with_last", done_cyc, last_strobe_cyc);
        check_val("full_busy_end", {31'd0, busy}, 32'd0);
        check_val("full_hold_cfg_in", {24'd0, cfg_in}, 32'h1F);
        check_val("full_hold_addr", {29'd0, cfg_addr}, 32'd7);
        check_val("full_sb_empty", sb_q.size(), 0);

        // Partial mask: y and cx only.
        clear_stats();
        push_expected(4'b1010, 8'h30, 16);
        do_start(4'b1010);
        send_stream(8'h30, 16, 1'b0, -1);
        idle_cycles(3);
        check_val("part_strobe_cnt", strobe_cnt, 16);
        check_val("part_done_cnt", done_cnt, 1);
        check_val("part_sb_empty", sb_q.size(), 0);

        // Empty mask.
        clear_stats();
        do_start(4'h0);
        idle_cycles(4);
        check_val("empty_strobe_cnt", strobe_cnt, 0);
        check_val("empty_done_cnt", done_cnt, 1);
        check_val("empty_ready_seen", {31'd0, ready_seen}, 32'd0);

        // Throttled input, x only.
        clear_stats();
        push_expected(4'h1, 8'hA0, 8);
        do_start(4'h1);
        send_stream(8'hA0, 8, 1'b1, -1);
        idle_cycles(3);
        check_val("thr_strobe_cnt", strobe_cnt, 8);
        check_val("thr_done_cnt", done_cnt, 1);
        check_val("thr_sb_empty", sb_q.size(), 0);

        // Abort after 5 transfers with in_valid still high.
        clear_stats();
        push_expected(4'hF, 8'h60, 5);
        do_start(4'hF);
        send_stream(8'h60, 5, 1'b0, -1);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        check_val("abort_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        check_val("abort_busy_low", {31'd0, busy}, 32'd0);
        idle_cycles(4);
        check_val("abort_strobe_cnt", strobe_cnt, 5);
        check_val("abort_done_cnt", done_cnt, 0);
        check_val("abort_sb_empty", sb_q.size(), 0);

        // Reload after abort restarts at block 0, field x.
        clear_stats();
        push_expected(4'hF, 8'h40, 32);
        do_start(4'hF);
        send_stream(8'h40, 32, 1'b0, -1);
        idle_cycles(3);
        check_val("reload_strobe_cnt", strobe_cnt, 32);
        check_val("reload_sb_empty", sb_q.size(), 0);

        // Simultaneous start and abort in IDLE: stays idle.
        clear_stats();
        start      = 1'b1;
        abort      = 1'b1;
        field_mask = 4'hF;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check_val("start_abort_busy", {31'd0, busy}, 32'd0);
        idle_cycles(2);
        check_val("start_abort_ready", {31'd0, ready_seen}, 32'd0);

        // Start pulsed mid-load is ignored.
        clear_stats();
        push_expected(4'hF, 8'h80, 32);
        do_start(4'hF);
        send_stream(8'h80, 32, 1'b0, 7);
        idle_cycles(3);
        check_val("ign_strobe_cnt", strobe_cnt, 32);
        check_val("ign_done_cnt", done_cnt, 1);
        check_val("ign_sb_empty", sb_q.size(), 0);

        // Reset mid-load: the strobe of the sixth byte is dropped.
        clear_stats();
        push_expected(4'hF, 8'hC0, 5);
        do_start(4'hF);
        send_stream(8'hC0, 6, 1'b0, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(1);
        check_val("midreset_strobe_cnt", strobe_cnt, 5);
        check_val("midreset_sb_empty", sb_q.size(), 0);

        // Load after reset starts from block 0.
        clear_stats();
        push_expected(4'h4, 8'hE0, 8);
        do_start(4'h4);
        send_stream(8'hE0, 8, 1'b0, -1);
        idle_cycles(3);
        check_val("post_reset_strobe_cnt", strobe_cnt, 8);
        check_val("post_reset_sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
